seg_scan_driver: RTL and testbench

- Display back-end for the call-billing account block.
- Consumes the packed-BCD call time (disptime, 2 digits) and remaining balance (dispmoney, 3 digits), and time-multiplexes them onto two independent scanned 7-segment channels.
- Channel 1 shows time and channel 0 shows money; the scan_en_* lines are binary digit indices for external decoders.
- Adds per-frame input latching (no tearing), leading-zero blanking on money, invalid-BCD flagging, and a warn-driven blink of the money channel.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/seg_scan_driver.sv | 113 +++++++++++
 tb/tb_seg_scan_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared segment constants and digit indices for the scanned 7-segment display path.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic       T_UNITS = 1'b0;
  localparam logic       T_TENS  = 1'b1;
  localparam logic [1:0] M_UNITS = 2'd0;
  localparam logic [1:0] M_TENS  = 2'd1;
  localparam logic [1:0] M_HUND  = 2'd2;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show "E".
module bcd_to_7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-channel scanned 7-segment driver: time (2 digits) and money (3 digits), with
// per-frame input latching, money leading-zero blanking and warn-driven money blink.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1,
  parameter int unsigned BLINK_HALF     = 250,
  parameter logic        SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk_1kHz,
  input  logic        clr,
  input  logic [7:0]  disptime,
  input  logic [11:0] dispmoney,
  input  logic        warn,
  output logic [2:0]  scan_en_1,
  output logic [6:0]  disptime_7seg,
  output logic [2:0]  scan_en_0,
  output logic [6:0]  dispmoney_7seg,
  output logic [3:0]  scan_data_1,
  output logic [3:0]  scan_data_0
);

  localparam logic [7:0] DIV_LAST   = 8'(SCAN_DIV - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);
  localparam logic [6:0] POL_MASK   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [7:0]  div;
  logic        idx_t;
  logic [1:0]  idx_m;
  logic [7:0]  lat_t;
  logic [11:0] lat_m;
  logic [9:0]  blink_cnt;
  logic        vis;

  logic        step;
  logic [3:0]  nib_t;
  logic [3:0]  nib_m;
  logic [6:0]  seg_t_raw;
  logic [6:0]  seg_m_raw;
  logic        blank_m;
  logic [6:0]  seg_m;

  assign step = (div == DIV_LAST);

  always_comb begin
    nib_t = (idx_t == T_TENS) ? lat_t[7:4] : lat_t[3:0];
    case (idx_m)
      M_UNITS: nib_m = lat_m[3:0];
      M_TENS:  nib_m = lat_m[7:4];
      default: nib_m = lat_m[11:8];
    endcase
  end

  bcd_to_7seg u_dec_t (.nibble(nib_t), .seg(seg_t_raw));
  bcd_to_7seg u_dec_m (.nibble(nib_m), .seg(seg_m_raw));

  // A zero test on the digit itself never matches an invalid nibble, so "E" is never blanked.
  always_comb begin
    blank_m = ((idx_m == M_HUND) && (lat_m[11:8] == 4'd0)) ||
              ((idx_m == M_TENS) && (lat_m[11:4] == 8'd0));
    seg_m   = (!vis || blank_m) ? SEG_BLANK : seg_m_raw;
  end

  always_ff @(posedge clk_1kHz) begin
    if (clr) begin
      div            <= '0;
      idx_t          <= T_UNITS;
      idx_m          <= M_UNITS;
      lat_t          <= '0;
      lat_m          <= '0;
      blink_cnt      <= '0;
      vis            <= 1'b1;
      scan_en_1      <= '0;
      disptime_7seg  <= '0;
      scan_en_0      <= '0;
      dispmoney_7seg <= '0;
      scan_data_1    <= '0;
      scan_data_0    <= '0;
    end else begin
      div <= step ? '0 : div + 8'd1;
      if (step) begin
        idx_t <= ~idx_t;
        if (idx_t == T_TENS) lat_t <= disptime;
        if (idx_m == M_HUND) begin
          idx_m <= M_UNITS;
          lat_m <= dispmoney;
        end else begin
          idx_m <= idx_m + 2'd1;
        end
      end

      if (warn) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          vis       <= ~vis;
        end else begin
          blink_cnt <= blink_cnt + 10'd1;
        end
      end else begin
        blink_cnt <= '0;
        vis       <= 1'b1;
      end

      scan_en_1      <= {2'b00, idx_t};
      scan_data_1    <= nib_t;
      disptime_7seg  <= seg_t_raw ^ POL_MASK;
      scan_en_0      <= {1'b0, idx_m};
      scan_data_0    <= nib_m;
      dispmoney_7seg <= seg_m ^ POL_MASK;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: two instances (default, and active-low with fast
// scan/blink) checked every cycle against a step-count based reference model.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  disptime;
  logic [11:0] dispmoney;
  logic        warn;

  logic [2:0] en1_a, en0_a, en1_b, en0_b;
  logic [6:0] seg1_a, seg0_a, seg1_b, seg0_b;
  logic [3:0] d1_a, d0_a, d1_b, d0_b;

  always #5 clk = ~clk;

  seg_scan_driver u_dut_a (
    .clk_1kHz(clk), .clr(clr), .disptime(disptime), .dispmoney(dispmoney), .warn(warn),
    .scan_en_1(en1_a), .disptime_7seg(seg1_a), .scan_en_0(en0_a),
    .dispmoney_7seg(seg0_a), .scan_data_1(d1_a), .scan_data_0(d0_a)
  );

  seg_scan_driver #(.SCAN_DIV(3), .BLINK_HALF(5), .SEG_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk_1kHz(clk), .clr(clr), .disptime(disptime), .dispmoney(dispmoney), .warn(warn),
    .scan_en_1(en1_b), .disptime_7seg(seg1_b), .scan_en_0(en0_b),
    .dispmoney_7seg(seg0_b), .scan_data_1(d1_b), .scan_data_0(d0_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, the cycle count since reset gives the step count,
  // which gives the digit positions; the warn run length gives the blink phase.
  int unsigned mdiv[2]  = '{1, 3};
  int unsigned mhalf[2] = '{250, 5};
  logic [6:0]  mpol[2]  = '{7'h00, 7'h7F};
  logic [6:0]  segtab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int unsigned cyc[2];
  int unsigned run[2];
  logic [7:0]  lt[2];
  logic [11:0] lm[2];
  logic [2:0]  e_en1[2], e_en0[2];
  logic [3:0]  e_d1[2], e_d0[2];
  logic [6:0]  e_s1[2], e_s0[2];
  bit          model_ok = 1'b0;

  function automatic logic [6:0] dec(input logic [3:0] n);
    if (n > 4'd9) return 7'h79;
    return segtab[n];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        cyc[i] = 0; run[i] = 0; lt[i] = '0; lm[i] = '0;
        e_en1[i] = '0; e_en0[i] = '0; e_d1[i] = '0; e_d0[i] = '0;
        e_s1[i] = '0; e_s0[i] = '0;
      end else begin
        int unsigned s, it, im;
        logic [7:0]  t8;
        logic [11:0] t12;
        logic        blank, visible;
        s   = cyc[i] / mdiv[i];
        it  = s % 2;
        im  = s % 3;
        t8  = lt[i] >> (4 * it);
        t12 = lm[i] >> (4 * im);
        blank   = (im == 2 && lm[i][11:8] == 4'd0) ||
                  (im == 1 && lm[i][11:8] == 4'd0 && lm[i][7:4] == 4'd0);
        visible = ((run[i] / mhalf[i]) % 2) == 0;
        e_en1[i] = 3'(it);
        e_d1[i]  = t8[3:0];
        e_s1[i]  = dec(t8[3:0]) ^ mpol[i];
        e_en0[i] = 3'(im);
        e_d0[i]  = t12[3:0];
        e_s0[i]  = ((!visible || blank) ? 7'h00 : dec(t12[3:0])) ^ mpol[i];
        if (cyc[i] % mdiv[i] == mdiv[i] - 1) begin
          if (s % 2 == 1) lt[i] = disptime;
          if (s % 3 == 2) lm[i] = dispmoney;
        end
        cyc[i]++;
        run[i] = warn ? run[i] + 1 : 0;
      end
    end
    if (clr) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("a_en1", en1_a, e_en1[0]);  check("a_d1", d1_a, e_d1[0]);
      check("a_seg1", seg1_a, e_s1[0]); check("a_en0", en0_a, e_en0[0]);
      check("a_d0", d0_a, e_d0[0]);     check("a_seg0", seg0_a, e_s0[0]);
      check("b_en1", en1_b, e_en1[1]);  check("b_d1", d1_b, e_d1[1]);
      check("b_seg1", seg1_b, e_s1[1]); check("b_en0", en0_b, e_en0[1]);
      check("b_d0", d0_b, e_d0[1]);     check("b_seg0", seg0_b, e_s0[1]);
    end
  end

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 2) == 0) return 4'd0;
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  int vis_cnt, dark_cnt;
  bit found;

  initial begin
    clr       = 1'b1;
    disptime  = 8'($urandom);
    dispmoney = 12'($urandom);
    warn      = 1'($urandom);
    repeat (5) @(negedge clk);
    check("rst_en1", en1_a, 0);  check("rst_seg1", seg1_a, 0);
    check("rst_seg0", seg0_a, 0); check("rst_b_seg0", seg0_b, 0);

    clr = 1'b0; disptime = 8'h42; dispmoney = 12'h305; warn = 1'b0;
    @(negedge clk);
    check("post_rst_en1", en1_a, 0);
    check("post_rst_seg1", seg1_a, 7'h3F);
    check("post_rst_b_seg1", seg1_b, 7'h40);
    repeat (12) @(negedge clk);
    dispmoney = 12'h012;
    repeat (12) @(negedge clk);
    dispmoney = 12'h007;
    repeat (10) @(negedge clk);
    dispmoney = 12'h0A0;
    repeat (10) @(negedge clk);
    disptime = 8'h88; dispmoney = 12'h008;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 600; k++) begin
      clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) disptime = {rnd_digit(), rnd_digit()};
      if ($urandom_range(0, 5) == 0) dispmoney = {rnd_digit(), rnd_digit(), rnd_digit()};
      if ($urandom_range(0, 39) == 0) warn = ~warn;
      @(negedge clk);
    end

    clr = 1'b0; warn = 1'b0; disptime = 8'h42; dispmoney = 12'h305;
    repeat (10) @(negedge clk);
    warn = 1'b1;
    vis_cnt = 0; dark_cnt = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (k < 250 && seg0_a != 7'h00) vis_cnt++;
      if (k >= 250 && seg0_a == 7'h00) dark_cnt++;
    end
    check("blink_visible", vis_cnt, 250);
    check("blink_dark", dark_cnt, 250);
    repeat (260) @(negedge clk);
    check("blink_dark2", seg0_a, 7'h00);
    warn = 1'b0;
    @(negedge clk);
    check("unblink_lag", seg0_a, 7'h00);
    @(negedge clk);
    check("unblink_visible", seg0_a != 7'h00, 1);

    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (en0_a == 3'd1) found = 1'b1;
    end
    check("find_idx_m2", found, 1);
    clr = 1'b1;
    @(negedge clk);
    check("midrst_en0", en0_a, 0);
    check("midrst_seg0", seg0_a, 0);
    check("midrst_b_seg1", seg1_b, 0);
    clr = 1'b0;
    @(negedge clk);
    check("midrst_post_en0", en0_a, 0);
    check("midrst_post_seg0", seg0_a, 7'h3F);
    check("midrst_post_b_seg0", seg0_b, 7'h40);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
